// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 16-bit pipelined core.
// Owns the PC, drives the instruction-memory read port and loads the IF/ID
// register. Branch redirects from EX take precedence over hazard stalls. A
// HALT word parks the stage until the next redirect. A saturating counter
// records the cycles spent stalled.
module fetch_stage #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                PCStall,
  input  logic                BranchTaken,
  input  logic [PC_WIDTH-1:0] BranchTarget,
  output logic [PC_WIDTH-1:0] IMemAddr,
  output logic                IMemReq,
  input  logic [15:0]         IMemData,
  input  logic                IMemReady,
  output logic [15:0]         IFID,
  output logic [PC_WIDTH-1:0] IFIDPC,
  output logic                IFIDValid,
  output logic                Halted,
  output logic [15:0]         StallCount
);

  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  typedef enum logic [1:0] {BOOT, FETCH, HALTED} state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ifid_q, ifid_d;
  logic [PC_WIDTH-1:0] ifidpc_q, ifidpc_d;
  logic                ifidv_q, ifidv_d;
  logic [15:0]         stall_q, stall_d;

  // Next-state logic: redirect beats stall, stall beats memory wait.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ifid_d   = ifid_q;
    ifidpc_d = ifidpc_q;
    ifidv_d  = ifidv_q;
    stall_d  = stall_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH, HALTED: begin
        if (BranchTaken) begin
          // IF/ID holds a wrong-path instruction: flush it, keep its PC tag.
          pc_d    = BranchTarget;
          ifid_d  = 16'h0000;
          ifidv_d = 1'b0;
          state_d = FETCH;
        end else if (PCStall) begin
          if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
        end else if (state_q == HALTED || !IMemReady) begin
          ifid_d  = 16'h0000;
          ifidv_d = 1'b0;
        end else begin
          ifid_d   = IMemData;
          ifidpc_d = pc_q + 1'b1;
          ifidv_d  = 1'b1;
          pc_d     = pc_q + 1'b1;
          if (IMemData == HALT_WORD) state_d = HALTED;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      ifid_q   <= 16'h0000;
      ifidpc_q <= '0;
      ifidv_q  <= 1'b0;
      stall_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ifid_q   <= ifid_d;
      ifidpc_q <= ifidpc_d;
      ifidv_q  <= ifidv_d;
      stall_q  <= stall_d;
    end
  end

  // Memory port comes from registered state only; no input-to-output path.
  assign IMemAddr   = pc_q;
  assign IMemReq    = (state_q == FETCH);
  assign IFID       = ifid_q;
  assign IFIDPC     = ifidpc_q;
  assign IFIDValid  = ifidv_q;
  assign Halted     = (state_q == HALTED);
  assign StallCount = stall_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus a
// per-cycle comparison against a behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        PCStall, BranchTaken, IMemReady;
  logic [15:0] BranchTarget;
  logic [15:0] IMemAddr, IMemData, IFID, IFIDPC, StallCount;
  logic        IMemReq, IFIDValid, Halted;

  int compared = 0, mismatched = 0;
  bit cmp_en = 1'b0;

  always #5 clock = ~clock;

  // Memory image: 4000+addr everywhere, with a HALT word at 0x0012.
  assign IMemData = (IMemAddr == 16'h0012) ? 16'hFFFF : 16'h4000 + IMemAddr;

  fetch_stage #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clock(clock), .reset(reset), .PCStall(PCStall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .IMemAddr(IMemAddr), .IMemReq(IMemReq),
    .IMemData(IMemData), .IMemReady(IMemReady), .IFID(IFID), .IFIDPC(IFIDPC),
    .IFIDValid(IFIDValid), .Halted(Halted), .StallCount(StallCount)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      if (mismatched <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=boot cycle, 1=fetching, 2=halted.
  int          m_mode;
  logic [15:0] m_pc, m_ifid, m_ifidpc, m_cnt;
  logic        m_v;

  always @(posedge clock) begin
    if (!reset) begin
      m_mode <= 0; m_pc <= 16'h0000; m_ifid <= 16'h0000; m_ifidpc <= 16'h0000;
      m_v <= 1'b0; m_cnt <= 16'h0000;
    end else if (m_mode == 0) begin
      m_mode <= 1;
    end else if (BranchTaken) begin
      m_pc <= BranchTarget; m_ifid <= 16'h0000; m_v <= 1'b0; m_mode <= 1;
    end else if (PCStall) begin
      m_cnt <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
    end else if (m_mode == 2 || !IMemReady) begin
      m_ifid <= 16'h0000; m_v <= 1'b0;
    end else begin
      m_ifid <= IMemData; m_ifidpc <= m_pc + 16'd1; m_v <= 1'b1; m_pc <= m_pc + 16'd1;
      if (IMemData == 16'hFFFF) m_mode <= 2;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("m_addr",  {16'h0, IMemAddr},   {16'h0, m_pc});
      chk("m_req",   {31'h0, IMemReq},    {31'h0, (m_mode == 1)});
      chk("m_ifid",  {16'h0, IFID},       {16'h0, m_ifid});
      chk("m_ifidpc",{16'h0, IFIDPC},     {16'h0, m_ifidpc});
      chk("m_valid", {31'h0, IFIDValid},  {31'h0, m_v});
      chk("m_halt",  {31'h0, Halted},     {31'h0, (m_mode == 2)});
      chk("m_stall", {16'h0, StallCount}, {16'h0, m_cnt});
    end
  end

  task automatic step();
    @(posedge clock); @(negedge clock); #1;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] addr, input logic req,
                         input logic [15:0] ifid, input logic [15:0] ipc, input logic v,
                         input logic h, input logic [15:0] cnt);
    chk({tag, "_addr"},  {16'h0, IMemAddr},   {16'h0, addr});
    chk({tag, "_req"},   {31'h0, IMemReq},    {31'h0, req});
    chk({tag, "_ifid"},  {16'h0, IFID},       {16'h0, ifid});
    chk({tag, "_ifidpc"},{16'h0, IFIDPC},     {16'h0, ipc});
    chk({tag, "_valid"}, {31'h0, IFIDValid},  {31'h0, v});
    chk({tag, "_halt"},  {31'h0, Halted},     {31'h0, h});
    chk({tag, "_stall"}, {16'h0, StallCount}, {16'h0, cnt});
  endtask

  initial begin
    reset = 1'b0; PCStall = 1'b0; BranchTaken = 1'b0; BranchTarget = 16'h0; IMemReady = 1'b1;
    step(); step();
    cmp_en = 1'b1;
    chk_out("reset", 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);

    // Release; this cycle is BOOT.
    reset = 1'b1;
    chk_out("boot", 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    step(); chk_out("first_req", 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    step(); chk_out("seq0", 16'h0001, 1, 16'h4000, 16'h0001, 1, 0, 16'h0000);
    step(); chk_out("seq1", 16'h0002, 1, 16'h4001, 16'h0002, 1, 0, 16'h0000);
    step(); chk_out("seq2", 16'h0003, 1, 16'h4002, 16'h0003, 1, 0, 16'h0000);
    step(); step(); step();
    chk_out("pre_stall", 16'h0006, 1, 16'h4005, 16'h0006, 1, 0, 16'h0000);

    // Three stall cycles hold everything and count.
    PCStall = 1'b1;
    step(); step(); step();
    chk_out("stall3", 16'h0006, 1, 16'h4005, 16'h0006, 1, 0, 16'h0003);
    PCStall = 1'b0;
    step(); chk_out("resume", 16'h0007, 1, 16'h4006, 16'h0007, 1, 0, 16'h0003);

    // Branch wins over a simultaneous stall.
    BranchTaken = 1'b1; BranchTarget = 16'h0100; PCStall = 1'b1;
    step(); chk_out("br_bubble", 16'h0100, 1, 16'h0000, 16'h0007, 0, 0, 16'h0003);
    BranchTaken = 1'b0; PCStall = 1'b0;
    step(); chk_out("br_target", 16'h0101, 1, 16'h4100, 16'h0101, 1, 0, 16'h0003);

    // Memory wait at 0x0010.
    BranchTaken = 1'b1; BranchTarget = 16'h0010;
    step(); BranchTaken = 1'b0; IMemReady = 1'b0;
    step(); chk_out("wait1", 16'h0010, 1, 16'h0000, 16'h0101, 0, 0, 16'h0003);
    step(); chk_out("wait2", 16'h0010, 1, 16'h0000, 16'h0101, 0, 0, 16'h0003);
    IMemReady = 1'b1;
    step(); chk_out("wait_done", 16'h0011, 1, 16'h4010, 16'h0011, 1, 0, 16'h0003);

    // HALT at 0x0012, one held stall cycle, a bubble, then redirect to 0x0020.
    step(); step();
    chk_out("halt_in", 16'h0013, 0, 16'hFFFF, 16'h0013, 1, 1, 16'h0003);
    PCStall = 1'b1;
    step(); chk_out("halt_stall", 16'h0013, 0, 16'hFFFF, 16'h0013, 1, 1, 16'h0004);
    PCStall = 1'b0;
    step(); chk_out("halt_bubble", 16'h0013, 0, 16'h0000, 16'h0013, 0, 1, 16'h0004);
    step(); chk_out("halt_park", 16'h0013, 0, 16'h0000, 16'h0013, 0, 1, 16'h0004);
    BranchTaken = 1'b1; BranchTarget = 16'h0020;
    step(); chk_out("halt_exit", 16'h0020, 1, 16'h0000, 16'h0013, 0, 0, 16'h0004);
    BranchTaken = 1'b0;
    step(); chk_out("halt_resume", 16'h0021, 1, 16'h4020, 16'h0021, 1, 0, 16'h0004);

    // PC wrap at all-ones.
    BranchTaken = 1'b1; BranchTarget = 16'hFFFF;
    step(); BranchTaken = 1'b0;
    chk("wrap_addr_pre", {16'h0, IMemAddr}, 32'h0000FFFF);
    step(); chk_out("wrap", 16'h0000, 1, 16'h3FFF, 16'h0000, 1, 0, 16'h0004);

    // Long stall saturates the counter.
    PCStall = 1'b1;
    for (int i = 0; i < 65540; i++) step();
    chk_out("sat", 16'h0000, 1, 16'h3FFF, 16'h0000, 1, 0, 16'hFFFF);

    // Reset in the middle of a stall.
    reset = 1'b0;
    step(); chk_out("mid_reset", 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    PCStall = 1'b0; reset = 1'b1;
    step(); step();
    chk_out("post_reset", 16'h0001, 1, 16'h4000, 16'h0001, 1, 0, 16'h0000);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
